// File: rtl/mac_feeder_if.sv
// Bundles the mac_feeder command, operand stream, MAC drive and result
// signals. The slave modport is the feeder's view; the master modport is the
// view of the surrounding logic (operand source, MAC and result consumer).
interface mac_feeder_if #(
   parameter int LEN_W = 16
);
   logic                start;
   logic [LEN_W-1:0]    len;
   logic signed [15:0]  op_a;
   logic signed [15:0]  op_b;
   logic                op_valid;
   logic                op_ready;
   logic signed [15:0]  mac_a;
   logic signed [15:0]  mac_b;
   logic                mac_en;
   logic                mac_clr;
   logic signed [31:0]  mac_acc;
   logic signed [31:0]  res;
   logic                res_valid;
   logic                res_ready;
   logic                busy;

   modport slave (
      input  start, len, op_a, op_b, op_valid, mac_acc, res_ready,
      output op_ready, mac_a, mac_b, mac_en, mac_clr, res, res_valid, busy
   );

   modport master (
      output start, len, op_a, op_b, op_valid, mac_acc, res_ready,
      input  op_ready, mac_a, mac_b, mac_en, mac_clr, res, res_valid, busy
   );
endinterface

// File: rtl/mac_feeder.sv
// mac_feeder: sequences one dot product through an external pipelined MAC.
// A start clears the MAC, streams len operand pairs into it (zero bubbles
// when the source stalls, enable held high so nothing is re-accumulated),
// waits out the MAC pipeline, captures the accumulator and holds it until
// the consumer takes it.
module mac_feeder #(
   parameter int LEN_W = 16,
   parameter int DRAIN = 4
) (
   input  logic        clk,
   input  logic        rst,
   mac_feeder_if.slave bus
);

   // Drain counter counts DRAIN-1 down to 0; the zero cycle is the capture cycle.
   localparam int                DCNT_W    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DRAIN - 1);
   localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
   localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [LEN_W-1:0]   rem_r;
   logic [LEN_W-1:0]   rem_s;
   logic [DCNT_W-1:0]  dcnt_r;
   logic [DCNT_W-1:0]  dcnt_s;
   logic signed [31:0] res_r;
   logic signed [31:0] res_s;

   logic               op_ready_r;
   logic               op_ready_s;
   logic               mac_en_r;
   logic               mac_en_s;
   logic               mac_clr_r;
   logic               mac_clr_s;
   logic               res_valid_r;
   logic               res_valid_s;
   logic               busy_r;
   logic               busy_s;

   // An operand pair is consumed when the source offers it while we are ready.
   logic               take_s;
   assign take_s = op_ready_r & bus.op_valid;

   // Next-state, remaining-count, drain-count and result-capture logic.
   always_comb begin
      state_s = state_r;
      rem_s   = rem_r;
      dcnt_s  = dcnt_r;
      res_s   = res_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               rem_s   = bus.len;
               state_s = ST_CLEAR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (rem_r != LEN_ZERO) begin
               state_s = ST_STREAM;
            end else begin
               state_s = ST_DRAIN;
               dcnt_s  = DCNT_LOAD;
            end
         end
         ST_STREAM: begin
            if (take_s) begin
               rem_s = rem_r - LEN_ONE;
               if (rem_r == LEN_ONE) begin
                  state_s = ST_DRAIN;
                  dcnt_s  = DCNT_LOAD;
               end else begin
                  state_s = ST_STREAM;
               end
            end else begin
               state_s = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if (dcnt_r == DCNT_ZERO) begin
               res_s   = bus.mac_acc;
               state_s = ST_DONE;
            end else begin
               dcnt_s  = dcnt_r - DCNT_ONE;
               state_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (bus.res_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the registered outputs line up
   // with the state they describe.
   always_comb begin
      op_ready_s  = 1'b0;
      mac_en_s    = 1'b0;
      mac_clr_s   = 1'b0;
      res_valid_s = 1'b0;
      case (state_s)
         ST_IDLE: begin
            op_ready_s = 1'b0;
         end
         ST_CLEAR: begin
            mac_clr_s = 1'b1;
         end
         ST_STREAM: begin
            op_ready_s = 1'b1;
            mac_en_s   = 1'b1;
         end
         ST_DRAIN: begin
            mac_en_s = 1'b1;
         end
         ST_DONE: begin
            res_valid_s = 1'b1;
         end
         default: begin
            op_ready_s = 1'b0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State, counters, captured result and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         rem_r       <= LEN_ZERO;
         dcnt_r      <= DCNT_ZERO;
         res_r       <= 32'sd0;
         op_ready_r  <= 1'b0;
         mac_en_r    <= 1'b0;
         mac_clr_r   <= 1'b0;
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         rem_r       <= rem_s;
         dcnt_r      <= dcnt_s;
         res_r       <= res_s;
         op_ready_r  <= op_ready_s;
         mac_en_r    <= mac_en_s;
         mac_clr_r   <= mac_clr_s;
         res_valid_r <= res_valid_s;
         busy_r      <= busy_s;
      end
   end

   // The MAC registers its operands, so passing the live pair (or a zero
   // bubble) straight through is safe; outside STREAM op_ready_r is low and
   // the MAC sees zeros.
   assign bus.mac_a     = take_s ? bus.op_a : 16'sd0;
   assign bus.mac_b     = take_s ? bus.op_b : 16'sd0;
   assign bus.op_ready  = op_ready_r;
   assign bus.mac_en    = mac_en_r;
   assign bus.mac_clr   = mac_clr_r;
   assign bus.res       = res_r;
   assign bus.res_valid = res_valid_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: a behavioural Q8 MAC with a DRAIN-cycle
// pipeline is attached to the feeder, and every result is compared with a
// plain arithmetic dot product of the pairs the bench offered.
module tb_mac_feeder;
   localparam int LEN_W = 16;
   localparam int DRAIN = 4;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mac_feeder_if #(.LEN_W(LEN_W)) bus ();

   mac_feeder #(.LEN_W(LEN_W), .DRAIN(DRAIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic signed [15:0] pa [0:15];
   logic signed [15:0] pb [0:15];

   // results of the last run_dot
   int r_lat;
   int r_consumed;
   int r_clr;
   bit r_en_ok;
   bit r_ready_seen;
   bit r_timeout;

   // Q8 product: shift right by 8, clamp to 16-bit signed.
   function automatic int qmul(input logic signed [15:0] a, input logic signed [15:0] b);
      int ia;
      int ib;
      int p;
      ia = a;
      ib = b;
      p  = (ia * ib) >>> 8;
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      return p;
   endfunction

   // Saturating 32-bit accumulate.
   function automatic int sat_add(input int acc, input int p);
      longint s;
      s = longint'(acc) + longint'(p);
      if (s > SMAX) s = SMAX;
      else if (s < SMIN) s = SMIN;
      return int'(s);
   endfunction

   // Expected dot product of the first n pairs.
   function automatic int model_dot(input int n);
      int acc;
      acc = 0;
      for (int i = 0; i < n; i++) acc = sat_add(acc, qmul(pa[i], pb[i]));
      return acc;
   endfunction

   // Reference MAC: accumulates on enable, re-adds its held product when
   // enable is low, result visible DRAIN cycles after the operands.
   int m_acc = 0;
   int m_held = 0;
   int m_dly [0:DRAIN-2] = '{default: 0};
   always @(posedge clk) begin
      if (bus.mac_clr) begin
         m_acc  <= 0;
         m_held <= 0;
         for (int i = 0; i < DRAIN - 1; i++) m_dly[i] <= 0;
      end else begin
         if (bus.mac_en) begin
            m_held <= qmul(bus.mac_a, bus.mac_b);
            m_acc  <= sat_add(m_acc, qmul(bus.mac_a, bus.mac_b));
         end else begin
            m_acc <= sat_add(m_acc, m_held);
         end
         m_dly[0] <= m_acc;
         for (int i = 1; i < DRAIN - 1; i++) m_dly[i] <= m_dly[i-1];
      end
   end
   assign bus.mac_acc = m_dly[DRAIN-2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a dot product of n pairs from pa/pb and act as operand source until
   // res_valid. gap_pct: random stall chance; fixed_gap: idle cycles forced
   // after the first pair. Junk pairs are offered once all real pairs are gone.
   task automatic run_dot(input int n, input int gap_pct, input int fixed_gap);
      int  idx;
      int  gap_left;
      bit  rdy;
      bit  drv_valid;
      bit  drv_real;
      idx          = 0;
      gap_left     = 0;
      r_lat        = 0;
      r_consumed   = 0;
      r_clr        = 0;
      r_en_ok      = 1'b1;
      r_ready_seen = 1'b0;
      r_timeout    = 1'b1;
      bus.op_valid = 1'b0;
      bus.start    = 1'b1;
      bus.len      = LEN_W'(n);
      tick();
      bus.start = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (bus.res_valid === 1'b1) begin
            r_timeout = 1'b0;
            break;
         end
         rdy = bus.op_ready;
         if (bus.mac_clr === 1'b1) r_clr++;
         if (rdy) begin
            r_ready_seen = 1'b1;
            if (bus.mac_en !== 1'b1) r_en_ok = 1'b0;
         end
         drv_real = 1'b0;
         if (idx < n) begin
            if (gap_left > 0) begin
               drv_valid = 1'b0;
               gap_left--;
            end else if ($urandom_range(99) >= gap_pct) begin
               drv_valid = 1'b1;
               drv_real  = 1'b1;
            end else begin
               drv_valid = 1'b0;
            end
         end else begin
            drv_valid = 1'b1;
         end
         bus.op_valid = drv_valid;
         bus.op_a     = drv_real ? pa[idx] : 16'($urandom);
         bus.op_b     = drv_real ? pb[idx] : 16'($urandom);
         tick();
         r_lat++;
         if (rdy && drv_valid) begin
            r_consumed++;
            if (drv_real) begin
               idx++;
               if (idx == 1) gap_left = fixed_gap;
            end
         end
      end
      bus.op_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.op_valid = 1'b1;
      bus.op_a     = 16'sd1234;
      bus.op_b     = -16'sd77;
      bus.res_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.op_ready, bus.mac_en, bus.mac_clr, bus.res_valid, bus.busy} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000", {bus.op_ready, bus.mac_en, bus.mac_clr, bus.res_valid, bus.busy});
      end
      checks++;
      if (bus.res !== 32'sd0 || bus.mac_a !== 16'sd0 || bus.mac_b !== 16'sd0) begin
         failures++;
         $display("FAIL reset_data got res=%0d a=%0d b=%0d exp=0", bus.res, bus.mac_a, bus.mac_b);
      end
      rst          = 1'b1;
      bus.op_valid = 1'b0;
      repeat (2) tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b ready=%b exp=0 0", bus.busy, bus.op_ready);
      end
   endtask

   task automatic test_basic();
      int exp;
      pa[0] = 16'sd256;  pb[0] = 16'sd256;
      pa[1] = 16'sd512;  pb[1] = 16'sd256;
      pa[2] = -16'sd256; pb[2] = 16'sd256;
      exp = model_dot(3);
      run_dot(3, 0, 0);
      checks++;
      if (r_timeout) begin failures++; $display("FAIL basic_timeout got=no res_valid exp=res_valid"); end
      checks++;
      if (r_lat != 1 + 3 + DRAIN) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", r_lat, 1 + 3 + DRAIN); end
      checks++;
      if (bus.res !== exp) begin failures++; $display("FAIL basic_res got=%0d exp=%0d", bus.res, exp); end
      checks++;
      if (r_consumed != 3 || r_clr != 1 || !r_en_ok) begin
         failures++;
         $display("FAIL basic_seq got consumed=%0d clr=%0d en_ok=%0d exp=3 1 1", r_consumed, r_clr, r_en_ok);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      checks++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res !== exp) begin
         failures++;
         $display("FAIL basic_release got valid=%b busy=%b res=%0d exp=0 0 %0d", bus.res_valid, bus.busy, bus.res, exp);
      end
   endtask

   task automatic test_gaps();
      int exp;
      pa[0] = 16'sd1024; pb[0] = 16'sd256;
      pa[1] = 16'sd256;  pb[1] = 16'sd256;
      exp = model_dot(2);
      run_dot(2, 0, 3);
      checks++;
      if (r_timeout || bus.res !== exp) begin failures++; $display("FAIL gap_res got=%0d exp=%0d", bus.res, exp); end
      checks++;
      if (!r_en_ok) begin failures++; $display("FAIL gap_mac_en got=dropped exp=held high"); end
      checks++;
      if (r_lat != 1 + 2 + 3 + DRAIN) begin failures++; $display("FAIL gap_latency got=%0d exp=%0d", r_lat, 1 + 2 + 3 + DRAIN); end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   task automatic test_len_zero();
      run_dot(0, 0, 0);
      checks++;
      if (r_timeout || bus.res !== 32'sd0) begin failures++; $display("FAIL zero_res got=%0d exp=0", bus.res); end
      checks++;
      if (r_lat != 1 + DRAIN) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", r_lat, 1 + DRAIN); end
      checks++;
      if (r_ready_seen || r_consumed != 0) begin
         failures++;
         $display("FAIL zero_ready got ready_seen=%0d consumed=%0d exp=0 0", r_ready_seen, r_consumed);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   task automatic test_hold();
      int exp;
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
         pa[i] = 16'($urandom);
         pb[i] = 16'($urandom);
      end
      exp = model_dot(n);
      run_dot(n, 20, 0);
      checks++;
      if (r_timeout || bus.res !== exp) begin failures++; $display("FAIL hold_res got=%0d exp=%0d", bus.res, exp); end
      for (int k = 0; k < 10; k++) begin
         bus.res_ready = 1'b0;
         bus.start     = (k % 2 == 0);
         bus.len       = 16'd3;
         tick();
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res !== exp || bus.busy !== 1'b1 || bus.mac_en !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable cycle=%0d got valid=%b res=%0d busy=%b en=%b exp=1 %0d 1 0",
                     k, bus.res_valid, bus.res, bus.busy, bus.mac_en, exp);
         end
      end
      bus.start     = 1'b0;
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      checks++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res !== exp) begin
         failures++;
         $display("FAIL hold_release got valid=%b busy=%b res=%0d exp=0 0 %0d", bus.res_valid, bus.busy, bus.res, exp);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.mac_clr !== 1'b0) begin
         failures++;
         $display("FAIL hold_start_ignored got busy=%b clr=%b exp=0 0", bus.busy, bus.mac_clr);
      end
   endtask

   task automatic test_reset_mid();
      int got;
      bit rdy;
      for (int i = 0; i < 5; i++) begin
         pa[i] = 16'sd768;
         pb[i] = 16'sd512;
      end
      got = 0;
      bus.op_valid = 1'b0;
      bus.start    = 1'b1;
      bus.len      = 16'd5;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         rdy          = bus.op_ready;
         bus.op_valid = 1'b1;
         bus.op_a     = pa[got];
         bus.op_b     = pb[got];
         tick();
         if (rdy) got++;
      end
      checks++;
      if (got != 2 || bus.busy !== 1'b1 || bus.op_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_setup got pairs=%0d busy=%b ready=%b exp=2 1 1", got, bus.busy, bus.op_ready);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.op_ready, bus.mac_en, bus.mac_clr, bus.res_valid, bus.busy} !== 5'b0 ||
          bus.res !== 32'sd0 || bus.mac_a !== 16'sd0 || bus.mac_b !== 16'sd0) begin
         failures++;
         $display("FAIL abort_outputs got ctrl=%b res=%0d a=%0d b=%0d exp=00000 0 0 0",
                  {bus.op_ready, bus.mac_en, bus.mac_clr, bus.res_valid, bus.busy}, bus.res, bus.mac_a, bus.mac_b);
      end
      bus.op_valid = 1'b0;
      tick();
      rst = 1'b1;
      repeat (3) tick();
      pa[0] = 16'sd256;
      pb[0] = 16'sd256;
      run_dot(1, 0, 0);
      checks++;
      if (r_timeout || bus.res !== model_dot(1)) begin
         failures++;
         $display("FAIL abort_rerun got=%0d exp=%0d", bus.res, model_dot(1));
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   task automatic test_saturation();
      int exp;
      for (int i = 0; i < 4; i++) begin
         pa[i] = 16'sd32767;
         pb[i] = 16'sd32767;
      end
      exp = model_dot(4);
      run_dot(4, 0, 0);
      checks++;
      if (r_timeout || bus.res !== exp) begin failures++; $display("FAIL sat_res got=%0d exp=%0d", bus.res, exp); end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   task automatic test_random();
      int n;
      int exp;
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
         end
         exp = model_dot(n);
         run_dot(n, 30, 0);
         checks++;
         if (r_timeout || bus.res !== exp || r_consumed != n || !r_en_ok) begin
            failures++;
            $display("FAIL random_run t=%0d n=%0d got res=%0d consumed=%0d en_ok=%0d exp res=%0d consumed=%0d en_ok=1",
                     t, n, bus.res, r_consumed, r_en_ok, exp, n);
         end
         bus.res_ready = 1'b1;
         tick();
         bus.res_ready = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_len_zero();
      test_hold();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
